// File: rtl/upper_stream.sv
// upper_stream: byte stream FIFO that upper-cases ASCII letters on entry.
//
// Bytes in the range 'a'..'z' have bit 5 cleared as they are pushed. Every
// other byte, including those with bit 7 set, is stored unchanged. The FIFO
// holds DEPTH entries. Two saturating counters report the total number of
// accepted bytes and how many of them were converted.
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    upstream byte present on in_data
//   in_data     upstream byte
//   in_ready    FIFO not full; independent of in_valid and out_ready
//   out_valid   FIFO not empty
//   out_data    head entry, 8'h00 while empty
//   out_ready   downstream accepts out_data
//   cnt_clr     synchronous clear of both counters; wins over an increment
//   level       current occupancy, 0..DEPTH
//   conv_count  accepted bytes that were lowercase (saturating)
//   byte_count  total accepted bytes (saturating)
module upper_stream #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  input  logic                     out_ready,
  input  logic                     cnt_clr,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         conv_count,
  output logic [CNT_W-1:0]         byte_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0]    LVL_ONE  = LW'(1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] conv_q, conv_d;
  logic [CNT_W-1:0] byte_q, byte_d;
  logic             in_ready_s;
  logic             out_valid_s;
  logic             push_s;
  logic             pop_s;
  logic             push_lower_s;

  // 'a'..'z' inclusive
  function automatic logic is_lower(input logic [7:0] b);
    is_lower = (b >= 8'd97) && (b <= 8'd122);
  endfunction

  function automatic logic [7:0] to_upper(input logic [7:0] b);
    if (is_lower(b)) begin
      to_upper = b & 8'hDF;
    end else begin
      to_upper = b;
    end
  endfunction

  // Handshake flags come from registered occupancy only, so in_ready never
  // depends combinationally on out_ready or in_valid.
  assign in_ready_s   = (level_q != FULL_LVL);
  assign out_valid_s  = (level_q != {LW{1'b0}});
  assign push_s       = in_valid && in_ready_s;
  assign pop_s        = out_valid_s && out_ready;
  assign push_lower_s = push_s && is_lower(in_data);

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_s;
  assign out_data   = out_valid_s ? mem_q[rd_ptr_q] : 8'h00;
  assign level      = level_q;
  assign conv_count = conv_q;
  assign byte_count = byte_q;

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = to_upper(in_data);
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    // Pointers wrap naturally (power-of-two depth); level is kept separately
    // so that full and empty are distinguishable.
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Next-state for the saturating counters; clear beats increment
  always_comb begin
    conv_d = conv_q;
    byte_d = byte_q;
    if (cnt_clr) begin
      conv_d = {CNT_W{1'b0}};
      byte_d = {CNT_W{1'b0}};
    end else begin
      if (push_s && (byte_q != CNT_MAX)) begin
        byte_d = byte_q + CNT_ONE;
      end else begin
        byte_d = byte_q;
      end
      if (push_lower_s && (conv_q != CNT_MAX)) begin
        conv_d = conv_q + CNT_ONE;
      end else begin
        conv_d = conv_q;
      end
    end
  end

  // State registers; storage is cleared too so no X can ever reach out_data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {LW{1'b0}};
      conv_q   <= {CNT_W{1'b0}};
      byte_q   <= {CNT_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      conv_q   <= conv_d;
      byte_q   <= byte_d;
    end
  end

endmodule

// File: tb/tb_upper_stream.sv
// tb_upper_stream: directed and random self-checking bench for upper_stream.
// A default instance (DEPTH=4, CNT_W=16) and a narrow-counter instance
// (CNT_W=3) share the same stimulus.
module tb_upper_stream;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_ready;
  logic        cnt_clr;

  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [2:0]  level;
  logic [15:0] conv_count;
  logic [15:0] byte_count;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [7:0]  s_out_data;
  logic [2:0]  s_level;
  logic [2:0]  s_conv_count;
  logic [2:0]  s_byte_count;

  int pass_cnt = 0;
  int total_cnt = 0;
  int fail_cnt = 0;

  upper_stream #(.DEPTH(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .cnt_clr(cnt_clr), .level(level),
    .conv_count(conv_count), .byte_count(byte_count)
  );

  upper_stream #(.DEPTH(4), .CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(s_in_ready), .out_valid(s_out_valid), .out_data(s_out_data),
    .out_ready(out_ready), .cnt_clr(cnt_clr), .level(s_level),
    .conv_count(s_conv_count), .byte_count(s_byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference conversion: lowercase letters shift down by 32
  function automatic logic [7:0] tb_ref(input logic [7:0] d);
    if (d >= 8'd97 && d <= 8'd122) return d - 8'd32;
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    total_cnt++; if (level !== 3'd0) $display("FAIL rst_level: got %0d expected 0", level); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 8'h00) $display("FAIL rst_out_data: got %h expected 00", out_data); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", in_ready); else pass_cnt++;
    total_cnt++; if (conv_count !== 16'd0) $display("FAIL rst_conv: got %0d expected 0", conv_count); else pass_cnt++;
    total_cnt++; if (byte_count !== 16'd0) $display("FAIL rst_byte: got %0d expected 0", byte_count); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total_cnt++; if (level !== 3'd0 || out_valid !== 1'b0) $display("FAIL rst_idle: got level %0d valid %b expected 0 0", level, out_valid); else pass_cnt++;
  endtask

  task automatic test_boundary();
    logic [7:0] vin  [5] = '{8'd96, 8'd97, 8'd122, 8'd123, 8'hE1};
    logic [7:0] vexp [5] = '{8'd96, 8'd65, 8'd90, 8'd123, 8'hE1};
    int k = 0;
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c < 5) begin
        in_valid = 1'b1;
        in_data  = vin[c];
      end else begin
        in_valid = 1'b0;
        in_data  = 8'h00;
      end
      if (out_valid) begin
        if (k < 5) begin
          total_cnt++; if (out_data !== vexp[k]) $display("FAIL bnd_data%0d: got %h expected %h", k, out_data, vexp[k]); else pass_cnt++;
        end
        k++;
      end
      step();
    end
    in_valid = 1'b0;
    total_cnt++; if (k !== 5) $display("FAIL bnd_count: got %0d bytes expected 5", k); else pass_cnt++;
    total_cnt++; if (conv_count !== 16'd2) $display("FAIL bnd_conv: got %0d expected 2", conv_count); else pass_cnt++;
    total_cnt++; if (byte_count !== 16'd5) $display("FAIL bnd_byte: got %0d expected 5", byte_count); else pass_cnt++;
    total_cnt++; if (level !== 3'd0) $display("FAIL bnd_level: got %0d expected 0", level); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int k = 0;
    logic sent = 1'b0;
    logic [7:0] e;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h61 + 8'(i);
      step();
    end
    in_data = 8'h65;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready: got %b expected 0", in_ready); else pass_cnt++;
    total_cnt++; if (level !== 3'd4) $display("FAIL bp_full_level: got %0d expected 4", level); else pass_cnt++;
    step();
    total_cnt++; if (level !== 3'd4) $display("FAIL bp_blocked_level: got %0d expected 4", level); else pass_cnt++;
    total_cnt++; if (out_data !== 8'h41) $display("FAIL bp_head_stable: got %h expected 41", out_data); else pass_cnt++;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) begin
        e = 8'h41 + 8'(k);
        total_cnt++; if (out_data !== e) $display("FAIL bp_data%0d: got %h expected %h", k, out_data, e); else pass_cnt++;
        k++;
      end
      if (in_valid && in_ready) sent = 1'b1;
      step();
      if (c == 0) begin
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_after_pop: got %b expected 1", in_ready); else pass_cnt++;
      end
      if (sent) in_valid = 1'b0;
    end
    total_cnt++; if (k !== 5 || sent !== 1'b1) $display("FAIL bp_count: got %0d bytes sent %b expected 5 1", k, sent); else pass_cnt++;
    total_cnt++; if (level !== 3'd0) $display("FAIL bp_level_end: got %0d expected 0", level); else pass_cnt++;
  endtask

  task automatic test_concurrent();
    string s = "hi Zebra {Q}u`ick@z[ya";
    logic [7:0] q [$];
    logic [7:0] e;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = s[i];
      q.push_back(tb_ref(s[i]));
      step();
    end
    out_ready = 1'b1;
    for (int i = 2; i < s.len(); i++) begin
      in_data = s[i];
      total_cnt++; if (level !== 3'd2) $display("FAIL cc_level%0d: got %0d expected 2", i, level); else pass_cnt++;
      e = q.pop_front();
      total_cnt++; if (out_data !== e) $display("FAIL cc_data%0d: got %h expected %h", i, out_data, e); else pass_cnt++;
      q.push_back(tb_ref(s[i]));
      step();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 6 && out_valid; c++) begin
      e = (q.size() > 0) ? q.pop_front() : 8'h00;
      total_cnt++; if (out_data !== e) $display("FAIL cc_drain%0d: got %h expected %h", c, out_data, e); else pass_cnt++;
      step();
    end
    total_cnt++; if (level !== 3'd0 || q.size() != 0) $display("FAIL cc_end: got level %0d left %0d expected 0 0", level, q.size()); else pass_cnt++;
  endtask

  task automatic test_saturation();
    in_valid = 1'b0;
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h61 + 8'(i);
      step();
    end
    total_cnt++; if (s_conv_count !== 3'd7) $display("FAIL sat_conv: got %0d expected 7", s_conv_count); else pass_cnt++;
    total_cnt++; if (s_byte_count !== 3'd7) $display("FAIL sat_byte: got %0d expected 7", s_byte_count); else pass_cnt++;
    total_cnt++; if (conv_count !== 16'd9) $display("FAIL wide_conv: got %0d expected 9", conv_count); else pass_cnt++;
    total_cnt++; if (byte_count !== 16'd9) $display("FAIL wide_byte: got %0d expected 9", byte_count); else pass_cnt++;
    total_cnt++; if (level !== 3'd1 || s_level !== 3'd1) $display("FAIL sat_level: got %0d/%0d expected 1", level, s_level); else pass_cnt++;
    out_ready = 1'b0;
    in_data   = 8'h71;
    cnt_clr   = 1'b1;
    step();
    cnt_clr  = 1'b0;
    in_valid = 1'b0;
    total_cnt++; if (s_conv_count !== 3'd0 || s_byte_count !== 3'd0) $display("FAIL clr_sat: got %0d/%0d expected 0/0", s_conv_count, s_byte_count); else pass_cnt++;
    total_cnt++; if (conv_count !== 16'd0 || byte_count !== 16'd0) $display("FAIL clr_wide: got %0d/%0d expected 0/0", conv_count, byte_count); else pass_cnt++;
    total_cnt++; if (level !== 3'd2) $display("FAIL clr_level: got %0d expected 2", level); else pass_cnt++;
    total_cnt++; if (out_data !== 8'h49) $display("FAIL clr_head: got %h expected 49", out_data); else pass_cnt++;
    total_cnt++; if (s_out_data !== 8'h49 || s_out_valid !== 1'b1 || s_in_ready !== 1'b1) $display("FAIL clr_sat_fifo: got %h %b %b expected 49 1 1", s_out_data, s_out_valid, s_in_ready); else pass_cnt++;
    out_ready = 1'b1;
    step();
    total_cnt++; if (out_data !== 8'h51) $display("FAIL clr_second: got %h expected 51", out_data); else pass_cnt++;
    step();
    total_cnt++; if (level !== 3'd0 || byte_count !== 16'd0) $display("FAIL clr_drain: got level %0d byte %0d expected 0 0", level, byte_count); else pass_cnt++;
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h72 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    total_cnt++; if (level !== 3'd3) $display("FAIL mid_level: got %0d expected 3", level); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (out_valid !== 1'b0 || out_data !== 8'h00) $display("FAIL mid_async: got valid %b data %h expected 0 00", out_valid, out_data); else pass_cnt++;
    total_cnt++; if (level !== 3'd0 || in_ready !== 1'b1 || byte_count !== 16'd0) $display("FAIL mid_async_state: got level %0d ready %b byte %0d expected 0 1 0", level, in_ready, byte_count); else pass_cnt++;
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h78;
    step();
    in_valid = 1'b0;
    total_cnt++; if (out_valid !== 1'b1 || out_data !== 8'd88) $display("FAIL mid_first: got valid %b data %h expected 1 58", out_valid, out_data); else pass_cnt++;
    total_cnt++; if (level !== 3'd1) $display("FAIL mid_first_level: got %0d expected 1", level); else pass_cnt++;
    out_ready = 1'b1;
    step();
    total_cnt++; if (out_valid !== 1'b0 || level !== 3'd0) $display("FAIL mid_after: got valid %b level %0d expected 0 0", out_valid, level); else pass_cnt++;
    total_cnt++; if (byte_count !== 16'd1 || conv_count !== 16'd1) $display("FAIL mid_counts: got %0d/%0d expected 1/1", byte_count, conv_count); else pass_cnt++;
  endtask

  task automatic test_random();
    localparam int N = 10000;
    logic [7:0] q [$];
    int pushed = 0;
    int conv_exp = 0;
    int errs = 0;
    logic [7:0] e;
    in_valid = 1'b0;
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    for (int c = 0; c < 60000 && !(pushed == N && q.size() == 0); c++) begin
      in_valid  = (pushed < N) && ($urandom_range(3) != 0);
      in_data   = 8'($urandom_range(255));
      out_ready = ($urandom_range(3) != 0);
      total_cnt++;
      if ($isunknown({in_ready, out_valid, out_data, level, conv_count, byte_count}) || int'(level) != q.size()) begin
        errs++;
        if (errs < 10) $display("FAIL rnd_state: got level %0d expected %0d", level, q.size());
      end else pass_cnt++;
      if (out_valid && out_ready) begin
        e = (q.size() > 0) ? q.pop_front() : 8'h00;
        total_cnt++;
        if (out_data !== e) begin
          errs++;
          if (errs < 10) $display("FAIL rnd_data: got %h expected %h", out_data, e);
        end else pass_cnt++;
      end
      if (in_valid && in_ready) begin
        q.push_back(tb_ref(in_data));
        if (in_data >= 8'd97 && in_data <= 8'd122) conv_exp++;
        pushed++;
      end
      step();
    end
    in_valid = 1'b0;
    total_cnt++; if (pushed != N || q.size() != 0) $display("FAIL rnd_done: got pushed %0d left %0d expected %0d 0", pushed, q.size(), N); else pass_cnt++;
    total_cnt++; if (int'(byte_count) != N) $display("FAIL rnd_byte: got %0d expected %0d", byte_count, N); else pass_cnt++;
    total_cnt++; if (int'(conv_count) != conv_exp) $display("FAIL rnd_conv: got %0d expected %0d", conv_count, conv_exp); else pass_cnt++;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    test_reset();
    test_boundary();
    test_backpressure();
    test_concurrent();
    test_saturation();
    test_reset_midstream();
    test_random();
    fail_cnt = total_cnt - pass_cnt;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
